// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM core pipeline buffers.
//   clog2        : ceiling log2 for parameter arithmetic
//   *_W          : default payload widths for the IF/ID/EXE stage bundles
//   *_bundle_t   : packed payload layouts carried between stages
package arm_pipe_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned CTRL_W       = 16;
  localparam int unsigned IF_ID_W      = INSTR_W + PC_W;
  localparam int unsigned ID_EXE_W     = INSTR_W + PC_W + CTRL_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_id_bundle_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [CTRL_W-1:0]  ctrl;
  } id_exe_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at its maximum value.
//   clk : clock
//   rst : asynchronous active-low reset, clears the count
//   en  : increment this cycle
//   cnt : registered count, saturates at 2^W-1
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_CNT = '1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage buffer: DEPTH-entry FIFO with valid/ready handshake,
// flush and a saturating stall counter.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   flush     : discard all stored entries; wins over push and pop
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake, oldest entry
//   count     : occupancy 0..DEPTH
//   stall_cnt : cycles with in_valid & !in_ready, saturating
module pipe_stage_buf
  import arm_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PTR_W:0]   count,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [PTR_W-1:0]            w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [PTR_W:0]              r_count, w_count_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic                        w_push, w_pop, w_stall;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake flags come from registered occupancy only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  assign w_stall = in_valid & ~in_ready;

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
      if (w_pop)  w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
        2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage; cleared on reset so out_data reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. Three instances share one stimulus:
//   u_d2 : DEPTH=2, CNT_W=16
//   u_d3 : DEPTH=3, CNT_W=16
//   u_c2 : DEPTH=2, CNT_W=2 (stall counter saturation)
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_out_data;
  logic [1:0]  d2_count;
  logic [15:0] d2_stall;

  logic        d3_in_ready, d3_out_valid;
  logic [31:0] d3_out_data;
  logic [2:0]  d3_count;
  logic [15:0] d3_stall;

  logic        c2_in_ready, c2_out_valid;
  logic [31:0] c2_out_data;
  logic [1:0]  c2_count;
  logic [1:0]  c2_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .count(d2_count), .stall_cnt(d2_stall)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(d3_in_ready), .in_data(in_data),
    .out_valid(d3_out_valid), .out_ready(out_ready), .out_data(d3_out_data),
    .count(d3_count), .stall_cnt(d3_stall)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
    .count(c2_count), .stall_cnt(c2_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse that opens and closes between clock edges.
  task automatic reset_pulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Test 3 table for DEPTH=3: one row per clock edge.
  int t3_iv   [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int t3_data [10] = '{'h30, 'h31, 'h32, 'h33, 'h34, 0, 0, 0, 0, 0};
  int t3_ordy [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int t3_front[10] = '{0, 'h30, 0, 'h31, 0, 'h32, 0, 'h33, 0, 'h34};
  int t3_cnt  [10] = '{1, 1, 2, 2, 3, 2, 2, 1, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_count",     32'(d2_count), 32'd0);
    chk("rst_in_ready",  32'(d2_in_ready), 32'd1);
    chk("rst_out_valid", 32'(d2_out_valid), 32'd0);
    chk("rst_stall",     32'(d2_stall), 32'd0);
    chk("rst_out_data",  d2_out_data, 32'd0);
    tick();
    rst = 1'b1;

    // 1: two back-to-back pushes with out_ready low fill DEPTH=2.
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk("t1_cnt1",  32'(d2_count), 32'd1);
    chk("t1_vld1",  32'(d2_out_valid), 32'd1);
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    chk("t1_cnt2",   32'(d2_count), 32'd2);
    chk("t1_rdy0",   32'(d2_in_ready), 32'd0);
    chk("t1_data",   d2_out_data, 32'hA);
    chk("t1_d3_rdy", 32'(d3_in_ready), 32'd1);
    chk("t1_stall",  32'(d2_stall), 32'd0);
    out_ready = 1'b1;
    chk("t1_pop_a", d2_out_data, 32'hA);
    tick();
    chk("t1_pop_b", d2_out_data, 32'hB);
    tick();
    chk("t1_empty_cnt", 32'(d2_count), 32'd0);
    chk("t1_empty_vld", 32'(d2_out_valid), 32'd0);

    // 2: continuous flow, one word per cycle, occupancy stays at 1.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + 32'(i);
      tick();
      chk("t2_cnt",  32'(d2_count), 32'd1);
      chk("t2_data", d2_out_data, 32'h100 + 32'(i));
      chk("t2_rdy",  32'(d2_in_ready), 32'd1);
      chk("t2_d3",   d3_out_data, 32'h100 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t2_drained", 32'(d2_count), 32'd0);

    // 3: DEPTH=3, pointers wrap; pop every other cycle.
    for (int c = 0; c < 10; c++) begin
      in_valid  = t3_iv[c][0];
      in_data   = 32'(t3_data[c]);
      out_ready = t3_ordy[c][0];
      if (t3_ordy[c] != 0) chk("t3_front", d3_out_data, 32'(t3_front[c]));
      tick();
      chk("t3_cnt", 32'(d3_count), 32'(t3_cnt[c]));
      if (c == 4) chk("t3_full_rdy", 32'(d3_in_ready), 32'd0);
    end

    // 4: full with pop: no same-cycle push, stall counted, ready next cycle.
    in_valid = 1'b0; out_ready = 1'b0;
    reset_pulse();
    chk("t4_rst_data", d2_out_data, 32'd0);
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("t4_full", 32'(d2_count), 32'd2);
    in_data = 32'hC; out_ready = 1'b1;
    chk("t4_rdy_full", 32'(d2_in_ready), 32'd0);
    tick();
    chk("t4_cnt",   32'(d2_count), 32'd1);
    chk("t4_stall", 32'(d2_stall), 32'd1);
    chk("t4_rdy",   32'(d2_in_ready), 32'd1);
    chk("t4_data",  d2_out_data, 32'hB);
    tick();
    chk("t4_cnt_c",  32'(d2_count), 32'd1);
    chk("t4_data_c", d2_out_data, 32'hC);
    chk("t4_stall2", 32'(d2_stall), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("t4_empty", 32'(d2_count), 32'd0);

    // 5: flush with count=2 and a simultaneous push on DEPTH=3.
    out_ready = 1'b0;
    reset_pulse();
    in_valid = 1'b1; in_data = 32'h51;
    tick();
    in_data = 32'h52;
    tick();
    chk("t5_cnt2", 32'(d3_count), 32'd2);
    chk("t5_rdy",  32'(d3_in_ready), 32'd1);
    flush = 1'b1; in_data = 32'h53;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_cnt0",     32'(d3_count), 32'd0);
    chk("t5_vld0",     32'(d3_out_valid), 32'd0);
    chk("t5_d2_cnt0",  32'(d2_count), 32'd0);
    chk("t5_d2_stall", 32'(d2_stall), 32'd1);
    in_valid = 1'b1; in_data = 32'h54;
    tick();
    in_valid = 1'b0;
    chk("t5_post_data", d3_out_data, 32'h54);
    chk("t5_post_cnt",  32'(d3_count), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t5_final_cnt", 32'(d3_count), 32'd0);
    chk("t5_final_vld", 32'(d3_out_valid), 32'd0);

    // 6: stall counter saturation (CNT_W=2), then an async reset mid-cycle.
    out_ready = 1'b0;
    reset_pulse();
    in_valid = 1'b1; in_data = 32'h61;
    tick();
    tick();
    chk("t6_c2_full", 32'(c2_count), 32'd2);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t6_c2_stall", 32'(c2_stall), (k > 3) ? 32'd3 : 32'(k));
      chk("t6_d2_stall", 32'(d2_stall), 32'(k));
    end
    rst = 1'b0;
    #1;
    chk("t6_rst_cnt",   32'(d2_count), 32'd0);
    chk("t6_rst_rdy",   32'(d2_in_ready), 32'd1);
    chk("t6_rst_vld",   32'(d2_out_valid), 32'd0);
    chk("t6_rst_data",  d2_out_data, 32'd0);
    chk("t6_rst_stall", 32'(d2_stall), 32'd0);
    chk("t6_rst_c2",    32'(c2_stall), 32'd0);
    chk("t6_rst_d3",    32'(d3_count), 32'd0);
    in_data = 32'h66;
    rst = 1'b1;
    tick();
    chk("t6_first_cnt",  32'(d2_count), 32'd1);
    chk("t6_first_data", d2_out_data, 32'h66);
    chk("t6_first_vld",  32'(d2_out_valid), 32'd1);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
